// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 single-wire pixel serialiser
// Streams NUM_LEDS pixels MSB first via the led_idx/pixel_in mux, then holds the latch low.
module ws2812_tx #(
   parameter int NUM_LEDS  = 8,
   parameter int IDX_W     = 3,
   parameter int T0H_CYC   = 20,
   parameter int T1H_CYC   = 40,
   parameter int BIT_CYC   = 63,
   parameter int RESET_CYC = 14000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [23:0]      pixel_in,
   output logic [IDX_W-1:0] led_idx,
   output logic             busy,
   output logic             done,
   output logic             dout
);
   localparam int CYC_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
   localparam int PIX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

   localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYC - 1);
   localparam logic [CYC_W-1:0] LATCH_LAST = CYC_W'(RESET_CYC - 1);
   localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NUM_LEDS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_LEDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

   state_t           state;
   logic [23:0]      shreg;
   logic [4:0]       bit_cnt;
   logic [PIX_W-1:0] pix_cnt;
   logic [CYC_W-1:0] cyc;

   function automatic logic [CYC_W-1:0] high_len(input logic b);
      return b ? CYC_W'(T1H_CYC) : CYC_W'(T0H_CYC);
   endfunction

   function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] i);
      return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
   endfunction

   // dout is registered from the next-cycle view of cyc/shreg so it lines up with cyc.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         led_idx <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
         pix_cnt <= '0;
         cyc     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               dout    <= 1'b0;
               led_idx <= '0;
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               shreg   <= pixel_in;
               led_idx <= idx_next('0);
               bit_cnt <= 5'd23;
               pix_cnt <= '0;
               cyc     <= '0;
               dout    <= (high_len(pixel_in[23]) != '0);
               state   <= SEND;
            end
            SEND: begin
               if (cyc == BIT_LAST) begin
                  cyc <= '0;
                  if (bit_cnt != 5'd0) begin
                     shreg   <= shreg << 1;
                     bit_cnt <= bit_cnt - 5'd1;
                     dout    <= (high_len(shreg[22]) != '0);
                  end else if (pix_cnt != PIX_LAST) begin
                     shreg   <= pixel_in;
                     bit_cnt <= 5'd23;
                     pix_cnt <= pix_cnt + PIX_W'(1);
                     led_idx <= idx_next(led_idx);
                     dout    <= (high_len(pixel_in[23]) != '0);
                  end else begin
                     dout  <= 1'b0;
                     state <= LATCH;
                  end
               end else begin
                  cyc  <= cyc + CYC_W'(1);
                  dout <= ((cyc + CYC_W'(1)) < high_len(shreg[23]));
               end
            end
            LATCH: begin
               dout <= 1'b0;
               if (cyc == LATCH_LAST) begin
                  cyc   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cyc <= cyc + CYC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
